board_map_writer: RTL and testbench

- Owns the 16x8 Tetris playfield bitmap and produces the `map` word that the dot-matrix display scanner reads.
- On a lock strobe it merges the four cells of the landed piece into the map, then removes full rows and shifts the rows above them down.
- Reports busy, a completion pulse, cleared-line count and game-over to the game controller.

---
 rtl/board_pkg.sv | 36 +++
 rtl/board_row_shifter.sv | 36 +++
 rtl/board_map_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_board_map_writer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared playfield definitions for the Tetris board logic: geometry constants,
// coordinate widths, the map-writer state encoding and the cell-index helper
// that both the map writer and the display scanner use to locate a cell bit.
//
// Optional build macro: BOARD_CLEAR_FLASH_EN adds the FLASH state.
// -----------------------------------------------------------------------------
package board_pkg;

   localparam int ROWS_DEF = 16;
   localparam int COLS     = 8;
   localparam int X_W      = 3;
   localparam int Y_W      = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MERGE = 3'd1,
      SCAN  = 3'd2,
      SHIFT = 3'd3,
`ifdef BOARD_CLEAR_FLASH_EN
      FIN   = 3'd4,
      FLASH = 3'd5
`else
      FIN   = 3'd4
`endif
   } state_e;

   // Bit index of cell (x, y) inside the map word: x + 8*y. With COLS=8 this
   // is simply the concatenation {y, x}, so no adder and no overflow.
   function automatic logic [X_W+Y_W-1:0] cell_idx(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
      return {y, x};
   endfunction

endpackage : board_pkg

// File: rtl/board_row_shifter.sv
// -----------------------------------------------------------------------------
// board_row_shifter
// Combinational row-removal datapath. Removes row row_i from the map: rows
// 1..row_i take the previous contents of rows 0..row_i-1, row 0 becomes empty,
// rows below row_i are passed through unchanged.
//
// Ports:
//   map_i  [COLS*ROWS-1:0]  current playfield (row r = bits [8r+7:8r])
//   row_i  [$clog2(ROWS)-1:0] index of the row being removed
//   map_o  [COLS*ROWS-1:0]  playfield after the removal
// -----------------------------------------------------------------------------
module board_row_shifter
   import board_pkg::*;
#(
   parameter int ROWS = ROWS_DEF
) (
   input  logic [COLS*ROWS-1:0]    map_i,
   input  logic [$clog2(ROWS)-1:0] row_i,
   output logic [COLS*ROWS-1:0]    map_o
);

   // Per-row select between "row above", "empty" and "unchanged".
   always_comb begin
      map_o = map_i;
      for (int k = 0; k < ROWS; k++) begin
         if (k == 0) begin
            map_o[COLS-1:0] = {COLS{1'b0}};
         end else if (k <= int'(row_i)) begin
            map_o[k*COLS +: COLS] = map_i[(k-1)*COLS +: COLS];
         end else begin
            map_o[k*COLS +: COLS] = map_i[k*COLS +: COLS];
         end
      end
   end

endmodule : board_row_shifter

// File: rtl/board_map_writer.sv
// -----------------------------------------------------------------------------
// board_map_writer
// Owns the 16x8 playfield bitmap. On an accepted lock strobe it merges the four
// landed cells into the map, scans every row top to bottom, removes each full
// row (shifting the rows above it down) and then reports completion.
//
// Ports:
//   CLK, RST                synchronous active-high reset
//   lock                    landed-piece strobe, accepted only when idle and
//                           not game over
//   block1..4_x / _y        cell coordinates, sampled on an accepted lock
//   map   [8*ROWS-1:0]      registered playfield for the display scanner
//   busy                    high from the cycle after lock until done
//   done                    one-cycle completion pulse
//   lines_last [2:0]        rows cleared by the last lock
//   lines_total [CNT_W-1:0] saturating cumulative cleared rows
//   game_over               sticky: collision on merge or residue in row 0
//
// Optional build macro: BOARD_CLEAR_FLASH_EN -- a full row blinks for
// 2^FLASH_W cycles before it is removed.
// -----------------------------------------------------------------------------
module board_map_writer
   import board_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int CNT_W = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 lock,
   input  logic [X_W-1:0]       block1_x,
   input  logic [X_W-1:0]       block2_x,
   input  logic [X_W-1:0]       block3_x,
   input  logic [X_W-1:0]       block4_x,
   input  logic [Y_W-1:0]       block1_y,
   input  logic [Y_W-1:0]       block2_y,
   input  logic [Y_W-1:0]       block3_y,
   input  logic [Y_W-1:0]       block4_y,
   output logic [COLS*ROWS-1:0] map,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           lines_last,
   output logic [CNT_W-1:0]     lines_total,
   output logic                 game_over
);

   localparam int MAP_W = COLS * ROWS;
   localparam int RW    = $clog2(ROWS);
   localparam logic [RW-1:0]    LAST_ROW = RW'(ROWS - 1);
   localparam logic [RW-1:0]    ROW_INC  = {{(RW-1){1'b0}}, 1'b1};
   localparam logic [MAP_W-1:0] BIT0     = {{(MAP_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_INC  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef BOARD_CLEAR_FLASH_EN
   localparam int FLASH_W = 20;
   logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
`endif

   state_e                 state_q, state_d;
   logic [MAP_W-1:0]       map_q, map_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [2:0]             lines_last_q, lines_last_d;
   logic [CNT_W-1:0]       lines_total_q, lines_total_d;
   logic                   game_over_q, game_over_d;
   logic [RW-1:0]          row_q, row_d;
   logic [3:0][X_W-1:0]    bx_q, bx_d;
   logic [3:0][Y_W-1:0]    by_q, by_d;

   logic [MAP_W-1:0]       cells_s;
   logic [MAP_W-1:0]       shift_map_s;
   logic                   row_full_s;
   logic                   row_last_s;

   board_row_shifter #(.ROWS(ROWS)) u_shifter (
      .map_i (map_q),
      .row_i (row_q),
      .map_o (shift_map_s)
   );

   // One-hot image of the four latched cells; duplicates simply overlap.
   always_comb begin
      cells_s = {MAP_W{1'b0}};
      for (int i = 0; i < 4; i++) begin
         cells_s = cells_s | (BIT0 << cell_idx(bx_q[i], by_q[i]));
      end
   end

   // Row-pointer status used by SCAN and SHIFT.
   always_comb begin
      row_full_s = (map_q[int'(row_q)*COLS +: COLS] == {COLS{1'b1}});
      row_last_s = (row_q == LAST_ROW);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      map_d         = map_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      lines_last_d  = lines_last_q;
      lines_total_d = lines_total_q;
      game_over_d   = game_over_q;
      row_d         = row_q;
      bx_d          = bx_q;
      by_d          = by_q;
`ifdef BOARD_CLEAR_FLASH_EN
      flash_cnt_d   = flash_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (lock && !game_over_q) begin
               bx_d    = {block4_x, block3_x, block2_x, block1_x};
               by_d    = {block4_y, block3_y, block2_y, block1_y};
               busy_d  = 1'b1;
               state_d = MERGE;
            end else begin
               state_d = IDLE;
            end
         end
         MERGE: begin
            map_d = map_q | cells_s;
            // Landing on an occupied cell means the stack reached the spawn area.
            if ((map_q & cells_s) != {MAP_W{1'b0}}) begin
               game_over_d = 1'b1;
            end else begin
               game_over_d = game_over_q;
            end
            row_d        = {RW{1'b0}};
            lines_last_d = 3'd0;
            state_d      = SCAN;
         end
         SCAN: begin
            if (row_full_s) begin
`ifdef BOARD_CLEAR_FLASH_EN
               flash_cnt_d = {FLASH_W{1'b0}};
               state_d     = FLASH;
`else
               state_d = SHIFT;
`endif
            end else if (row_last_s) begin
               state_d = FIN;
            end else begin
               row_d   = row_q + ROW_INC;
               state_d = SCAN;
            end
         end
`ifdef BOARD_CLEAR_FLASH_EN
         FLASH: begin
            flash_cnt_d = flash_cnt_q + {{(FLASH_W-1){1'b0}}, 1'b1};
            // Bit FLASH_W-2 toggles every 2^(FLASH_W-2) cycles: blank, lit, blank, lit.
            map_d[int'(row_q)*COLS +: COLS] = {COLS{flash_cnt_q[FLASH_W-2]}};
            if (flash_cnt_q == {FLASH_W{1'b1}}) begin
               state_d = SHIFT;
            end else begin
               state_d = FLASH;
            end
         end
`endif
         SHIFT: begin
            map_d        = shift_map_s;
            lines_last_d = lines_last_q + 3'd1;
            if (lines_total_q != CNT_MAX) begin
               lines_total_d = lines_total_q + CNT_INC;
            end else begin
               lines_total_d = lines_total_q;
            end
            // The row moved into row_q came from above and was already seen not full.
            if (row_last_s) begin
               state_d = FIN;
            end else begin
               row_d   = row_q + ROW_INC;
               state_d = SCAN;
            end
         end
         FIN: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            if (map_q[COLS-1:0] != {COLS{1'b0}}) begin
               game_over_d = 1'b1;
            end else begin
               game_over_d = game_over_q;
            end
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         map_q         <= {MAP_W{1'b0}};
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         lines_last_q  <= 3'd0;
         lines_total_q <= {CNT_W{1'b0}};
         game_over_q   <= 1'b0;
         row_q         <= {RW{1'b0}};
         bx_q          <= {(4*X_W){1'b0}};
         by_q          <= {(4*Y_W){1'b0}};
`ifdef BOARD_CLEAR_FLASH_EN
         flash_cnt_q   <= {FLASH_W{1'b0}};
`endif
      end else begin
         state_q       <= state_d;
         map_q         <= map_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         lines_last_q  <= lines_last_d;
         lines_total_q <= lines_total_d;
         game_over_q   <= game_over_d;
         row_q         <= row_d;
         bx_q          <= bx_d;
         by_q          <= by_d;
`ifdef BOARD_CLEAR_FLASH_EN
         flash_cnt_q   <= flash_cnt_d;
`endif
      end
   end

   assign map         = map_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign lines_last  = lines_last_q;
   assign lines_total = lines_total_q;
   assign game_over   = game_over_q;

endmodule : board_map_writer

// File: tb/tb_board_map_writer.sv
// -----------------------------------------------------------------------------
// tb_board_map_writer
// Directed, table-driven bench for board_map_writer: a sequence of locks with
// hand-computed maps, latencies and line counts, followed by hand-written
// sequences for collision / game over, lock while busy and reset mid-scan.
// -----------------------------------------------------------------------------
module tb_board_map_writer;

   typedef struct {
      logic [3:0][2:0] xs;
      logic [3:0][3:0] ys;
      int              lat;
      logic [2:0]      last;
      logic [7:0]      total;
      logic [127:0]    exp_map;
   } vec_t;

   logic         CLK;
   logic         RST;
   logic         lock;
   logic [2:0]   block1_x, block2_x, block3_x, block4_x;
   logic [3:0]   block1_y, block2_y, block3_y, block4_y;
   logic [127:0] map;
   logic         busy;
   logic         done;
   logic [2:0]   lines_last;
   logic [7:0]   lines_total;
   logic         game_over;

   int   n_cmp;
   int   n_fail;
   vec_t tbl[16];

   board_map_writer dut (
      .CLK         (CLK),
      .RST         (RST),
      .lock        (lock),
      .block1_x    (block1_x),
      .block2_x    (block2_x),
      .block3_x    (block3_x),
      .block4_x    (block4_x),
      .block1_y    (block1_y),
      .block2_y    (block2_y),
      .block3_y    (block3_y),
      .block4_y    (block4_y),
      .map         (map),
      .busy        (busy),
      .done        (done),
      .lines_last  (lines_last),
      .lines_total (lines_total),
      .game_over   (game_over)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic [2:0] x0, input logic [3:0] y0,
                               input logic [2:0] x1, input logic [3:0] y1,
                               input logic [2:0] x2, input logic [3:0] y2,
                               input logic [2:0] x3, input logic [3:0] y3,
                               input int lat, input logic [2:0] last,
                               input logic [7:0] total, input logic [127:0] m);
      vec_t v;
      v.xs      = {x3, x2, x1, x0};
      v.ys      = {y3, y2, y1, y0};
      v.lat     = lat;
      v.last    = last;
      v.total   = total;
      v.exp_map = m;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one lock pulse; returns at the negedge after the sampling edge.
   task automatic pulse_lock(input logic [3:0][2:0] xs, input logic [3:0][3:0] ys);
      @(negedge CLK);
      block1_x = xs[0]; block2_x = xs[1]; block3_x = xs[2]; block4_x = xs[3];
      block1_y = ys[0]; block2_y = ys[1]; block3_y = ys[2]; block4_y = ys[3];
      lock = 1'b1;
      @(negedge CLK);
      lock = 1'b0;
   endtask

   // Count clock edges (starting from 'start') until done is seen, bounded.
   task automatic wait_done(input int start, output int edges);
      edges = start;
      while (done !== 1'b1 && edges < 100) begin
         @(negedge CLK);
         edges++;
      end
   endtask

   initial begin
      int edges;
      logic [3:0][2:0] xs;
      logic [3:0][3:0] ys;
      n_cmp  = 0;
      n_fail = 0;
      RST  = 1'b1;
      lock = 1'b0;
      block1_x = 3'd0; block2_x = 3'd0; block3_x = 3'd0; block4_x = 3'd0;
      block1_y = 4'd0; block2_y = 4'd0; block3_y = 4'd0; block4_y = 4'd0;

      // Each map constant lists rows from 15 (bottom, MSB) down to 0.
      tbl[0]  = mk(3'd3,4'd15, 3'd4,4'd15, 3'd3,4'd14, 3'd4,4'd14, 19, 3'd0, 8'd0, {8'h18, 8'h18, 112'h0});
      tbl[1]  = mk(3'd5,4'd15, 3'd6,4'd15, 3'd7,4'd15, 3'd5,4'd14, 19, 3'd0, 8'd0, {8'hF8, 8'h38, 112'h0});
      tbl[2]  = mk(3'd0,4'd15, 3'd1,4'd15, 3'd2,4'd15, 3'd0,4'd14, 20, 3'd1, 8'd1, {8'h39, 120'h0});
      tbl[3]  = mk(3'd1,4'd15, 3'd2,4'd15, 3'd6,4'd15, 3'd6,4'd15, 19, 3'd0, 8'd1, {8'h7F, 120'h0});
      tbl[4]  = mk(3'd0,4'd14, 3'd1,4'd14, 3'd2,4'd14, 3'd3,4'd14, 19, 3'd0, 8'd1, {8'h7F, 8'h0F, 112'h0});
      tbl[5]  = mk(3'd4,4'd14, 3'd5,4'd14, 3'd6,4'd14, 3'd6,4'd14, 19, 3'd0, 8'd1, {8'h7F, 8'h7F, 112'h0});
      tbl[6]  = mk(3'd0,4'd13, 3'd1,4'd13, 3'd2,4'd13, 3'd3,4'd13, 19, 3'd0, 8'd1, {8'h7F, 8'h7F, 8'h0F, 104'h0});
      tbl[7]  = mk(3'd4,4'd13, 3'd5,4'd13, 3'd6,4'd13, 3'd6,4'd13, 19, 3'd0, 8'd1, {8'h7F, 8'h7F, 8'h7F, 104'h0});
      tbl[8]  = mk(3'd0,4'd12, 3'd1,4'd12, 3'd2,4'd12, 3'd3,4'd12, 19, 3'd0, 8'd1, {8'h7F, 8'h7F, 8'h7F, 8'h0F, 96'h0});
      tbl[9]  = mk(3'd4,4'd12, 3'd5,4'd12, 3'd6,4'd12, 3'd6,4'd12, 19, 3'd0, 8'd1, {8'h7F, 8'h7F, 8'h7F, 8'h7F, 96'h0});
      tbl[10] = mk(3'd7,4'd12, 3'd7,4'd13, 3'd7,4'd14, 3'd7,4'd15, 23, 3'd4, 8'd5, 128'h0);
      tbl[11] = mk(3'd0,4'd15, 3'd1,4'd15, 3'd2,4'd15, 3'd3,4'd15, 19, 3'd0, 8'd5, {8'h0F, 120'h0});
      tbl[12] = mk(3'd4,4'd15, 3'd5,4'd15, 3'd6,4'd15, 3'd0,4'd14, 19, 3'd0, 8'd5, {8'h7F, 8'h01, 112'h0});
      tbl[13] = mk(3'd0,4'd13, 3'd1,4'd13, 3'd2,4'd13, 3'd3,4'd13, 19, 3'd0, 8'd5, {8'h7F, 8'h01, 8'h0F, 104'h0});
      tbl[14] = mk(3'd4,4'd13, 3'd5,4'd13, 3'd6,4'd13, 3'd6,4'd13, 19, 3'd0, 8'd5, {8'h7F, 8'h01, 8'h7F, 104'h0});
      tbl[15] = mk(3'd7,4'd15, 3'd7,4'd13, 3'd7,4'd12, 3'd7,4'd12, 21, 3'd2, 8'd7, {8'h01, 8'h80, 112'h0});

      // Reset state.
      repeat (3) @(negedge CLK);
      chk("rst map", map, 128'h0);
      chk("rst busy", {127'h0, busy}, 128'h0);
      chk("rst done", {127'h0, done}, 128'h0);
      chk("rst lines_last", {125'h0, lines_last}, 128'h0);
      chk("rst lines_total", {120'h0, lines_total}, 128'h0);
      chk("rst game_over", {127'h0, game_over}, 128'h0);
      RST = 1'b0;

      // Table-driven lock sequence.
      for (int i = 0; i < 16; i++) begin
         pulse_lock(tbl[i].xs, tbl[i].ys);
         wait_done(1, edges);
         chk($sformatf("v%0d latency", i), 128'(edges), 128'(tbl[i].lat));
         chk($sformatf("v%0d map", i), map, tbl[i].exp_map);
         chk($sformatf("v%0d lines_last", i), {125'h0, lines_last}, {125'h0, tbl[i].last});
         chk($sformatf("v%0d lines_total", i), {120'h0, lines_total}, {120'h0, tbl[i].total});
         chk($sformatf("v%0d busy", i), {127'h0, busy}, 128'h0);
         chk($sformatf("v%0d game_over", i), {127'h0, game_over}, 128'h0);
      end

      // Collision: (0,15) already set -> game_over right after MERGE.
      xs = {3'd3, 3'd2, 3'd1, 3'd0};
      ys = {4'd15, 4'd15, 4'd15, 4'd15};
      pulse_lock(xs, ys);
      @(negedge CLK);
      chk("coll game_over after merge", {127'h0, game_over}, 128'h1);
      chk("coll map after merge", map, {8'h0F, 8'h80, 112'h0});
      wait_done(2, edges);
      chk("coll latency", 128'(edges), 128'd19);
      chk("coll game_over sticky", {127'h0, game_over}, 128'h1);
      // Lock while game over is ignored.
      xs = {3'd7, 3'd6, 3'd5, 3'd4};
      ys = {4'd0, 4'd0, 4'd0, 4'd0};
      pulse_lock(xs, ys);
      chk("gameover lock busy", {127'h0, busy}, 128'h0);
      repeat (3) @(negedge CLK);
      chk("gameover lock busy later", {127'h0, busy}, 128'h0);
      chk("gameover lock map", map, {8'h0F, 8'h80, 112'h0});
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("rst clears game_over", {127'h0, game_over}, 128'h0);
      chk("rst clears map", map, 128'h0);
      chk("rst clears lines_total", {120'h0, lines_total}, 128'h0);

      // Lock while busy has no effect.
      xs = {3'd3, 3'd2, 3'd1, 3'd0};
      ys = {4'd15, 4'd15, 4'd15, 4'd15};
      pulse_lock(xs, ys);
      repeat (2) @(negedge CLK);
      chk("busy during op", {127'h0, busy}, 128'h1);
      xs = {3'd7, 3'd6, 3'd5, 3'd4};
      ys = {4'd10, 4'd10, 4'd10, 4'd10};
      pulse_lock(xs, ys);
      wait_done(5, edges);
      chk("busylock latency", 128'(edges), 128'd19);
      chk("busylock map", map, {8'h0F, 120'h0});
      @(negedge CLK);
      chk("done one cycle", {127'h0, done}, 128'h0);
      repeat (3) @(negedge CLK);
      chk("busylock not queued", {127'h0, busy}, 128'h0);
      chk("busylock map stays", map, {8'h0F, 120'h0});

      // Reset while scanning row 5 aborts to reset values.
      xs = {3'd7, 3'd6, 3'd5, 3'd4};
      ys = {4'd15, 4'd15, 4'd15, 4'd15};
      pulse_lock(xs, ys);
      repeat (6) @(negedge CLK);
      chk("scan5 busy", {127'h0, busy}, 128'h1);
      chk("scan5 map merged", map, {8'hFF, 120'h0});
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("abort map", map, 128'h0);
      chk("abort busy", {127'h0, busy}, 128'h0);
      chk("abort done", {127'h0, done}, 128'h0);
      chk("abort lines_last", {125'h0, lines_last}, 128'h0);
      chk("abort lines_total", {120'h0, lines_total}, 128'h0);
      chk("abort game_over", {127'h0, game_over}, 128'h0);
      repeat (25) @(negedge CLK);
      chk("abort no done later", {127'h0, done}, 128'h0);

      // Cells left in row 0 end the game at FIN.
      xs = {3'd3, 3'd2, 3'd1, 3'd0};
      ys = {4'd0, 4'd0, 4'd0, 4'd0};
      pulse_lock(xs, ys);
      @(negedge CLK);
      chk("row0 no game_over at merge", {127'h0, game_over}, 128'h0);
      wait_done(2, edges);
      chk("row0 latency", 128'(edges), 128'd19);
      chk("row0 map", map, {120'h0, 8'h0F});
      chk("row0 game_over", {127'h0, game_over}, 128'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_board_map_writer
